// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned BE_W = 4;

  function automatic logic [31:0] be_merge(
    input logic [31:0]     old_w,
    input logic [31:0]     wdata,
    input logic [BE_W-1:0] be
  );
    logic [31:0] merged;
    merged = old_w;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-enabled synchronous write and combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [DATA_W-1:0] o_rdata
);

  // Deliberately never reset: contents survive responder resets.
  logic [DATA_W-1:0] data_memory [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) data_memory[i_addr] <= be_merge(data_memory[i_addr], i_wdata, i_be);
  end

  assign o_rdata = data_memory[i_addr];

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding load/store responder with programmable access latency.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned CNT_W = 4;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_accept;
  logic                w_commit;
  logic                w_we;
  logic [31:0]         w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [BE_W-1:0]     w_be;
  logic                w_err;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_mem_we;
  logic [DATA_W-1:0]   w_mem_rdata;

  assign req_ready = (r_state == IDLE) && rst;
  assign w_accept  = req_valid && req_ready;

  // LATENCY==1 commits on the acceptance edge itself, so the live request
  // fields are used in IDLE and the latched copy otherwise.
  assign w_commit = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                    ((r_state == WAIT) && (r_cnt == CNT_W'(1)));
  assign w_we     = (r_state == IDLE) ? req_we    : r_we;
  assign w_addr   = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_wdata  = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_be     = (r_state == IDLE) ? req_be    : r_be;

  assign w_err    = (w_addr[1:0] != 2'b00) || (w_addr[31:ADDR_W+2] != '0);
  assign w_idx    = w_addr[ADDR_W+1:2];
  assign w_mem_we = w_commit && w_we && !w_err && rst;

  dmem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .i_be    (w_be),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= WAIT;
            r_cnt   <= CNT_W'(LATENCY - 1);
          end
        end
        WAIT: r_cnt <= r_cnt - CNT_W'(1);
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_commit) begin
        r_state     <= RESP;
        r_rsp_valid <= 1'b1;
        r_rdata     <= (!w_we && !w_err) ? w_mem_rdata : '0;
        r_err       <= w_err;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
